systolic_tile_scheduler: RTL and testbench

Sequences the systolic array controller over a multi-tile matrix job. Accepts a job command (tile counts in M and N), then repeatedly issues a one-cycle start to the array controller and waits for its done. It presents tile indices and buffer base addresses for each tile, and handshakes each finished output tile to the result writeback engine. Sits between the host/DMA command interface and the per-tile array controller.

---
 rtl/systolic_pkg.sv | 21 ++
 rtl/systolic_tile_scheduler_perf_counters.sv | 32 +++
 rtl/systolic_tile_scheduler.sv | 156 +++++++++++++++
 tb/tb_systolic_tile_scheduler.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and tile-size helpers for the systolic tile scheduler.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    WB,
    DONE
  } sched_state_t;

  // Words in one A (or B, called with cols) input tile: array edge times reduction depth.
  function automatic int tile_a_words(input int rows, input int k);
    return rows * k;
  endfunction

  function automatic int tile_c_words(input int rows, input int cols);
    return rows * cols;
  endfunction

endpackage

// File: rtl/systolic_tile_scheduler_perf_counters.sv
// Saturating run/writeback-stall cycle counters for the tile scheduler.
// Only compiled when SCHED_PERF_EN is defined.
`ifdef SCHED_PERF_EN
module sched_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_run_inc,
  input  logic        i_stall_inc,
  output logic [31:0] o_run_cycles,
  output logic [31:0] o_stall_cycles
);

  logic [1:0] w_inc;
  assign w_inc = {i_stall_inc, i_run_inc};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [31:0] r_cnt;
    always_ff @(posedge clk) begin
      if (rst || i_clr) begin
        r_cnt <= '0;
      end else if (w_inc[gi] && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  assign o_run_cycles   = g_cnt[0].r_cnt;
  assign o_stall_cycles = g_cnt[1].r_cnt;

endmodule
`endif

// File: rtl/systolic_tile_scheduler.sv
// Walks an M x N tile job row-major: start array, wait done, hand tile to writeback.
// Optional SCHED_PERF_EN adds run/stall cycle counter outputs.
module systolic_tile_scheduler
  import systolic_pkg::*;
#(
  parameter  int ROWS      = 4,
  parameter  int COLS      = 4,
  parameter  int K         = 4,
  parameter  int MAX_TILES = 16,
  parameter  int ADDR_W    = 16,
  localparam int CW        = $clog2(MAX_TILES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CW-1:0]     cmd_tiles_m,
  input  logic [CW-1:0]     cmd_tiles_n,
  input  logic              abort,
  output logic              arr_start,
  input  logic              arr_done,
  output logic [CW-1:0]     tile_m,
  output logic [CW-1:0]     tile_n,
  output logic [ADDR_W-1:0] a_base,
  output logic [ADDR_W-1:0] b_base,
  output logic [ADDR_W-1:0] c_base,
  output logic              wb_req,
  input  logic              wb_ack,
  output logic              busy,
  output logic              done,
  output logic              aborted
`ifdef SCHED_PERF_EN
  ,
  output logic [31:0]       perf_run_cycles,
  output logic [31:0]       perf_wb_stall_cycles
`endif
);

  localparam int            A_STEP  = tile_a_words(ROWS, K);
  localparam int            B_STEP  = tile_a_words(COLS, K);
  localparam int            C_STEP  = tile_c_words(ROWS, COLS);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_TILES);

  sched_state_t      r_state, w_state_next;
  logic [CW-1:0]     r_tiles_m, r_tiles_n, r_tile_m, r_tile_n;
  logic [CW-1:0]     w_tiles_m_next, w_tiles_n_next, w_tile_m_next, w_tile_n_next;
  logic [CW-1:0]     w_cmd_m_clamp, w_cmd_n_clamp;
  logic              r_abort_pend, w_abort_pend_next;
  logic [ADDR_W-1:0] r_a_base, r_b_base, r_c_base;
  logic              w_accept, w_last_n, w_last;

  assign w_cmd_m_clamp = (cmd_tiles_m > MAX_CNT) ? MAX_CNT : cmd_tiles_m;
  assign w_cmd_n_clamp = (cmd_tiles_n > MAX_CNT) ? MAX_CNT : cmd_tiles_n;
  assign w_accept      = (r_state == IDLE) && cmd_valid;
  assign w_last_n      = (r_tile_n == r_tiles_n - CW'(1));
  assign w_last        = w_last_n && (r_tile_m == r_tiles_m - CW'(1));

  always_comb begin
    w_state_next      = r_state;
    w_tiles_m_next    = r_tiles_m;
    w_tiles_n_next    = r_tiles_n;
    w_tile_m_next     = r_tile_m;
    w_tile_n_next     = r_tile_n;
    w_abort_pend_next = r_abort_pend;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_tiles_m_next    = w_cmd_m_clamp;
          w_tiles_n_next    = w_cmd_n_clamp;
          w_tile_m_next     = '0;
          w_tile_n_next     = '0;
          w_abort_pend_next = 1'b0;
          w_state_next      = ((w_cmd_m_clamp == '0) || (w_cmd_n_clamp == '0)) ? DONE : START;
        end
      end
      START: begin
        if (abort) w_abort_pend_next = 1'b1;
        w_state_next = RUN;
      end
      RUN: begin
        if (abort) w_abort_pend_next = 1'b1;
        if (arr_done) w_state_next = WB;
      end
      WB: begin
        if (abort) w_abort_pend_next = 1'b1;
        if (wb_ack) begin
          // An abort seen in this very cycle still ends the job after this tile.
          if (r_abort_pend || abort || w_last) begin
            w_state_next = DONE;
          end else begin
            w_state_next = START;
            if (w_last_n) begin
              w_tile_n_next = '0;
              w_tile_m_next = r_tile_m + CW'(1);
            end else begin
              w_tile_n_next = r_tile_n + CW'(1);
            end
          end
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Bases are registered from the next indices so they line up with the index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_tiles_m    <= '0;
      r_tiles_n    <= '0;
      r_tile_m     <= '0;
      r_tile_n     <= '0;
      r_abort_pend <= 1'b0;
      r_a_base     <= '0;
      r_b_base     <= '0;
      r_c_base     <= '0;
    end else begin
      r_state      <= w_state_next;
      r_tiles_m    <= w_tiles_m_next;
      r_tiles_n    <= w_tiles_n_next;
      r_tile_m     <= w_tile_m_next;
      r_tile_n     <= w_tile_n_next;
      r_abort_pend <= w_abort_pend_next;
      r_a_base     <= ADDR_W'(w_tile_m_next) * ADDR_W'(A_STEP);
      r_b_base     <= ADDR_W'(w_tile_n_next) * ADDR_W'(B_STEP);
      r_c_base     <= (ADDR_W'(w_tile_m_next) * ADDR_W'(w_tiles_n_next) + ADDR_W'(w_tile_n_next))
                      * ADDR_W'(C_STEP);
    end
  end

  assign cmd_ready = (r_state == IDLE);
  assign arr_start = (r_state == START);
  assign wb_req    = (r_state == WB);
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign aborted   = (r_state == DONE) && r_abort_pend;
  assign tile_m    = r_tile_m;
  assign tile_n    = r_tile_n;
  assign a_base    = r_a_base;
  assign b_base    = r_b_base;
  assign c_base    = r_c_base;

`ifdef SCHED_PERF_EN
  sched_perf_counters u_perf (
    .clk            (clk),
    .rst            (rst),
    .i_clr          (w_accept),
    .i_run_inc      (r_state == RUN),
    .i_stall_inc    ((r_state == WB) && !wb_ack),
    .o_run_cycles   (perf_run_cycles),
    .o_stall_cycles (perf_wb_stall_cycles)
  );
`endif

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// Directed bench for systolic_tile_scheduler with a small array/writeback responder.
module tb_systolic_tile_scheduler;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst, cmd_valid, abort, arr_done, wb_ack;
  logic [CW-1:0] cmd_tiles_m, cmd_tiles_n;
  logic          cmd_ready, arr_start, wb_req, busy, done, aborted;
  logic [CW-1:0] tile_m, tile_n;
  logic [15:0]   a_base, b_base, c_base;
`ifdef SCHED_PERF_EN
  logic [31:0]   perf_run_cycles, perf_wb_stall_cycles;
`endif

  always #5 clk = ~clk;

  systolic_tile_scheduler dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_tiles_m(cmd_tiles_m), .cmd_tiles_n(cmd_tiles_n), .abort(abort),
    .arr_start(arr_start), .arr_done(arr_done), .tile_m(tile_m), .tile_n(tile_n),
    .a_base(a_base), .b_base(b_base), .c_base(c_base), .wb_req(wb_req), .wb_ack(wb_ack),
    .busy(busy), .done(done), .aborted(aborted)
`ifdef SCHED_PERF_EN
    , .perf_run_cycles(perf_run_cycles), .perf_wb_stall_cycles(perf_wb_stall_cycles)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  int cyc, n_start, n_done, n_ack, done_ab, done_cyc, first_start, busy_cnt;
  int idx_unstable, wbreq_late, ack_start_bad, stall_hold, last_ack, finished;
  int rec_m[64], rec_n[64], rec_a[64], rec_b[64], rec_c[64];
  int exp_m[6] = '{0, 0, 0, 1, 1, 1};
  int exp_n[6] = '{0, 1, 2, 0, 1, 2};
  int exp_a[6] = '{0, 0, 0, 16, 16, 16};
  int exp_b[6] = '{0, 16, 32, 0, 16, 32};
  int exp_c[6] = '{0, 16, 32, 48, 64, 80};

  // Drives one job; the responder returns arr_done 8 cycles after each start.
  task automatic run_job(input int tm, input int tn, input int stall_tile, input int stall_cyc,
                         input int abort_tile, input int rst_tile);
    int timer    = -1;
    int wait_cnt = 0;
    int done_drv = -100;
    int in_tile  = 0;
    int cur;
    n_start = 0; n_done = 0; n_ack = 0; done_ab = -1; done_cyc = -1; first_start = -1;
    busy_cnt = 0; idx_unstable = 0; wbreq_late = 0; ack_start_bad = 0; stall_hold = 0;
    last_ack = -100; finished = 0;
    @(negedge clk);
    cyc = 0;
    chk("cmd_ready_before_accept", int'(cmd_ready), 1);
    cmd_valid   = 1'b1;
    cmd_tiles_m = CW'(tm);
    cmd_tiles_n = CW'(tn);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      cyc++;
      cmd_valid = 1'b0; arr_done = 1'b0; wb_ack = 1'b0; abort = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        n_done++; done_ab = int'(aborted); done_cyc = cyc; finished = 1;
        break;
      end
      if (arr_start) begin
        if (n_start == 0) first_start = cyc;
        else if (cyc != last_ack + 1) ack_start_bad++;
        rec_m[n_start] = int'(tile_m); rec_n[n_start] = int'(tile_n);
        rec_a[n_start] = int'(a_base); rec_b[n_start] = int'(b_base);
        rec_c[n_start] = int'(c_base);
        n_start++; timer = 8; wait_cnt = 0; in_tile = 1;
      end else if (timer > 0) begin
        timer--;
        if (timer == 0) begin arr_done = 1'b1; done_drv = cyc; end
      end
      cur = n_start - 1;
      if (in_tile != 0 && (int'(tile_m) != rec_m[cur] || int'(tile_n) != rec_n[cur] ||
          int'(a_base) != rec_a[cur] || int'(b_base) != rec_b[cur] || int'(c_base) != rec_c[cur]))
        idx_unstable++;
      if (cur == abort_tile && timer == 4) abort = 1'b1;
      if (wb_req) begin
        if (wait_cnt == 0 && cyc != done_drv + 1) wbreq_late++;
        if (cur == rst_tile) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          finished = 1;
          break;
        end
        if (wait_cnt >= ((cur == stall_tile) ? stall_cyc : 0)) begin
          wb_ack = 1'b1; last_ack = cyc; in_tile = 0; n_ack++;
          if (cur == stall_tile) stall_hold = wait_cnt + 1;
        end
        wait_cnt++;
      end
    end
    chk("job_finished", finished, 1);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_cmd_ready"}, int'(cmd_ready), 1);
    chk({pfx, "_arr_start"}, int'(arr_start), 0);
    chk({pfx, "_wb_req"},    int'(wb_req), 0);
    chk({pfx, "_busy"},      int'(busy), 0);
    chk({pfx, "_done"},      int'(done), 0);
    chk({pfx, "_aborted"},   int'(aborted), 0);
    chk({pfx, "_tile_mn"},   int'({tile_m, tile_n}), 0);
    chk({pfx, "_bases"},     int'(a_base) + int'(b_base) + int'(c_base), 0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0; arr_done = 1'b0; wb_ack = 1'b0;
    cmd_tiles_m = '0; cmd_tiles_n = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // 2x3 job; abort held high while idle must be ignored.
    abort = 1'b1;
    run_job(2, 3, -1, 0, -1, -1);
    chk("t1_starts", n_start, 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t1_tile_m[%0d]", i), rec_m[i], exp_m[i]);
      chk($sformatf("t1_tile_n[%0d]", i), rec_n[i], exp_n[i]);
      chk($sformatf("t1_a_base[%0d]", i), rec_a[i], exp_a[i]);
      chk($sformatf("t1_b_base[%0d]", i), rec_b[i], exp_b[i]);
      chk($sformatf("t1_c_base[%0d]", i), rec_c[i], exp_c[i]);
    end
    chk("t1_first_start_cycle", first_start, 1);
    chk("t1_done_count", n_done, 1);
    chk("t1_aborted", done_ab, 0);
    chk("t1_done_after_ack", done_cyc, last_ack + 1);
    chk("t1_busy_cycles", busy_cnt, done_cyc);
    chk("t1_idx_unstable", idx_unstable, 0);
    chk("t1_wbreq_late", wbreq_late, 0);
    chk("t1_ack_to_start", ack_start_bad, 0);
    @(negedge clk);
    chk("t1_ready_after_done", int'(cmd_ready), 1);

    // Zero-count job.
    run_job(0, 5, -1, 0, -1, -1);
    chk("t2_starts", n_start, 0);
    chk("t2_done_cycle", done_cyc, 1);
    chk("t2_busy_cycles", busy_cnt, 1);
    chk("t2_aborted", done_ab, 0);

    // Writeback stall of 5 cycles on tile 1 of a 2x2 job.
    run_job(2, 2, 1, 5, -1, -1);
    chk("t3_starts", n_start, 4);
    chk("t3_wbreq_hold", stall_hold, 6);
    chk("t3_idx_unstable", idx_unstable, 0);
    chk("t3_ack_to_start", ack_start_bad, 0);
    chk("t3_tile2", rec_m[2] * 16 + rec_n[2], 16);
`ifdef SCHED_PERF_EN
    chk("t3_perf_stall", int'(perf_wb_stall_cycles), 5);
    chk("t3_perf_run", int'(perf_run_cycles), 32);
`endif

    // Abort during RUN of tile (0,1) of a 2x2 job.
    run_job(2, 2, -1, 0, 1, -1);
    chk("t4_starts", n_start, 2);
    chk("t4_acks", n_ack, 2);
    chk("t4_tile1", rec_m[1] * 16 + rec_n[1], 1);
    chk("t4_aborted", done_ab, 1);
    chk("t4_done_count", n_done, 1);

    // Reset during first writeback of a 3x3 job, then a fresh 1x1 job.
    run_job(3, 3, -1, 0, -1, 0);
    chk("t5_done_count", n_done, 0);
    chk_reset_outputs("t5_after_rst");
    run_job(1, 1, -1, 0, -1, -1);
    chk("t5b_starts", n_start, 1);
    chk("t5b_done_count", n_done, 1);
    chk("t5b_aborted", done_ab, 0);

    // Oversized row count clamps to 16.
    run_job(31, 1, -1, 0, -1, -1);
    chk("t6_starts", n_start, 16);
    chk("t6_last_tile_m", rec_m[15], 15);
    chk("t6_last_a_base", rec_a[15], 240);
    chk("t6_last_c_base", rec_c[15], 240);
    chk("t6_done_count", n_done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
